// File: rtl/acc_writeback_if.sv
// acc_writeback_if: bundles the two handshaked buses around the writeback stage.
//   Upstream beat   : in_valid/in_ready plus the instruction payload
//                     (is_a, imm, alu_o, alu_ng, alu_zr, dest, jmp).
//   Memory write    : mem_wr_valid/mem_wr_ready plus mem_wr_addr/mem_wr_data.
// Modports:
//   slave  - the writeback stage (consumes beats, produces memory writes)
//   master - the environment (ALU stage and RAM port)
interface acc_writeback_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic             is_a;
   logic [WIDTH-2:0] imm;
   logic [WIDTH-1:0] alu_o;
   logic             alu_ng;
   logic             alu_zr;
   logic [2:0]       dest;
   logic [2:0]       jmp;
   logic             mem_wr_valid;
   logic             mem_wr_ready;
   logic [WIDTH-1:0] mem_wr_addr;
   logic [WIDTH-1:0] mem_wr_data;

   modport slave (
      input  in_valid, is_a, imm, alu_o, alu_ng, alu_zr, dest, jmp, mem_wr_ready,
      output in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
   );

   modport master (
      output in_valid, is_a, imm, alu_o, alu_ng, alu_zr, dest, jmp, mem_wr_ready,
      input  in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/acc_writeback.sv
// acc_writeback: retire stage after the 16-bit ALU.
// Updates the A/D accumulators, registers the ALU flags, evaluates the jump
// condition and issues memory writes over a valid/ready handshake. While a
// write is outstanding the stage stalls upstream by dropping in_ready.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   bus (slave)   - upstream beat handshake + payload, memory write handshake
//   a_reg, d_reg  - accumulators feeding the ALU
//   flag_ng/zr    - flags of the last compute instruction
//   jump_taken    - one-cycle pulse when the retired instruction jumps
//   jump_target   - A value (before the instruction) used as jump target
//   retired       - wrapping count of accepted instructions
module acc_writeback #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   acc_writeback_if.slave    bus,
   output logic [WIDTH-1:0]  a_reg,
   output logic [WIDTH-1:0]  d_reg,
   output logic              flag_ng,
   output logic              flag_zr,
   output logic              jump_taken,
   output logic [WIDTH-1:0]  jump_target,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic {IDLE, WR_WAIT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             ng_q, ng_d;
   logic             zr_q, zr_d;
   logic             jt_q, jt_d;
   logic [WIDTH-1:0] jtgt_q, jtgt_d;
   logic             wv_q, wv_d;
   logic [WIDTH-1:0] wa_q, wa_d;
   logic [WIDTH-1:0] wd_q, wd_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic             cond;

   // Flags are taken verbatim from the ALU; gt is "neither negative nor zero".
   assign cond = (bus.jmp[2] & bus.alu_ng) |
                 (bus.jmp[1] & bus.alu_zr) |
                 (bus.jmp[0] & ~bus.alu_ng & ~bus.alu_zr);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      ng_d    = ng_q;
      zr_d    = zr_q;
      jt_d    = 1'b0;        // jump_taken is a single-cycle pulse
      jtgt_d  = jtgt_q;
      wv_d    = wv_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      ret_d   = ret_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               ret_d = ret_q + 1'b1;
               if (bus.is_a) begin
                  a_d = {1'b0, bus.imm};
               end else begin
                  if (bus.dest[2]) a_d = bus.alu_o;
                  if (bus.dest[1]) d_d = bus.alu_o;
                  ng_d   = bus.alu_ng;
                  zr_d   = bus.alu_zr;
                  jt_d   = cond;
                  // Address and target use A as it was before this instruction.
                  jtgt_d = a_q;
                  if (bus.dest[0]) begin
                     wa_d    = a_q;
                     wd_d    = bus.alu_o;
                     wv_d    = 1'b1;
                     state_d = WR_WAIT;
                  end
               end
            end
         end
         WR_WAIT: begin
            if (bus.mem_wr_ready) begin
               wv_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         d_q     <= '0;
         ng_q    <= 1'b0;
         zr_q    <= 1'b0;
         jt_q    <= 1'b0;
         jtgt_q  <= '0;
         wv_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         ng_q    <= ng_d;
         zr_q    <= zr_d;
         jt_q    <= jt_d;
         jtgt_q  <= jtgt_d;
         wv_q    <= wv_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         ret_q   <= ret_d;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.mem_wr_valid = wv_q;
   assign bus.mem_wr_addr  = wa_q;
   assign bus.mem_wr_data  = wd_q;
   assign a_reg            = a_q;
   assign d_reg            = d_q;
   assign flag_ng          = ng_q;
   assign flag_zr          = zr_q;
   assign jump_taken       = jt_q;
   assign jump_target      = jtgt_q;
   assign retired          = ret_q;

endmodule
